// File: rtl/priority_request_latch.sv
// Sticky request capture with per-line masking, presented one line at a time
// as a highest-index-first 4-bit index over a valid/ready handshake.
module priority_request_latch #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             edge_mode,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [N-1:0]     req_q,       req_d;
  logic [N-1:0]     pending_q,   pending_d;
  logic             overflow_q,  overflow_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;

  logic [N-1:0] cap;
  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic         acc;
  logic         ovf_set;

  function automatic logic [IDX_W-1:0] highest_idx(input logic [N-1:0] v);
    highest_idx = '0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < N; i++) begin
      if (v[i]) highest_idx = IDX_W'(i);
    end
  endfunction

  always_comb begin
    cap     = edge_mode ? (req & ~req_q) : req;
    acc     = out_valid_q & out_ready;
    clr     = acc ? (N'(1) << out_idx_q) : '0;
    elig    = pending_q & ~mask;
    ovf_set = edge_mode & (|(cap & pending_q & ~clr));
  end

  // Capture is OR-ed after the clear so a same-cycle arrival keeps its bit.
  always_comb begin
    req_d      = req;
    pending_d  = (pending_q & ~clr) | cap;
    overflow_d = ovf_set | (overflow_q & ~clr_ovf);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (elig != '0) begin
          state_d     = ST_PRESENT;
          out_valid_d = 1'b1;
          out_idx_d   = highest_idx(elig);
        end
      end
      ST_PRESENT: begin
        // The presented index is never retracted, even for a higher arrival.
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_idx_d   = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
